// File: rtl/load_unit_if.sv
// load_unit_if: word-read bus between the load unit and the data memory.
interface load_unit_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
   modport slave (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/load_unit.sv
// load_unit: executes lw/lh/lhu/lb/lbu over a req/gnt/rvalid memory bus,
// aligning and extending the returned word for writeback.
module load_unit #(
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_valid,
   input  logic [1:0]        ld_size,
   input  logic              ld_unsigned,
   input  logic [31:0]       ld_addr,
   input  logic [4:0]        ld_rd,
   output logic              ld_ready,
   output logic              stall,
   load_unit_if.master       bus,
   output logic              res_valid,
   output logic [31:0]       res_data,
   output logic [4:0]        res_rd,
   output logic              misalign,
   output logic              bus_err
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
   state_t state, state_n;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [4:0]  rd_q;
   logic [CW-1:0] cnt;
   logic        accept, aligned, timeout;
   logic [7:0]  byte_f;
   logic [15:0] half_f;
   logic [31:0] ext;

   assign aligned = ld_size == 2'b01 ? ld_addr[1:0] == 2'b00 : ld_size == 2'b10 ? !ld_addr[0] : 1'b1;
   assign accept  = state == IDLE && ld_valid && ld_size != 2'b00;
   assign timeout = cnt == CW'(TIMEOUT - 1);

   assign ld_ready     = state == IDLE;
   assign stall        = state != IDLE || (accept && aligned);
   assign bus.mem_req  = state == REQ;
   assign bus.mem_addr = {addr_q[31:2], 2'b00};
   assign res_valid    = state == RESP;

   assign byte_f = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
   assign half_f = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
   assign ext    = size_q == 2'b01 ? bus.mem_rdata
                 : size_q == 2'b10 ? {{16{!uns_q && half_f[15]}}, half_f}
                 : {{24{!uns_q && byte_f[7]}}, byte_f};

   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = accept && aligned ? REQ : IDLE;
         REQ: state_n = bus.mem_gnt ? WAIT : REQ;
         // rvalid takes priority over a timeout in the same cycle
         WAIT: state_n = bus.mem_rvalid ? RESP : timeout ? IDLE : WAIT;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (reset) begin
         addr_q   <= '0;
         size_q   <= '0;
         uns_q    <= 1'b0;
         rd_q     <= '0;
         cnt      <= '0;
         res_data <= '0;
         res_rd   <= '0;
         misalign <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         misalign <= accept && !aligned;
         bus_err  <= state == WAIT && !bus.mem_rvalid && timeout;
         if (accept && aligned) begin
            addr_q <= ld_addr;
            size_q <= ld_size;
            uns_q  <= ld_unsigned;
            rd_q   <= ld_rd;
         end
         if (state == REQ && bus.mem_gnt) cnt <= '0;
         else if (state == WAIT) cnt <= cnt + 1'b1;
         if (state == WAIT && bus.mem_rvalid) begin
            res_data <= ext;
            res_rd   <= rd_q;
         end
      end
endmodule
